// File: rtl/llr_fetch_ctrl_pkg.sv
// Shared types and constants for the LLR fetch controller: FSM states,
// memory-map geometry and the legal code lengths.
package llr_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_CNT   = 3'd1,
    ST_RD_HDR   = 3'd2,
    ST_CFG      = 3'd3,
    ST_STREAM   = 3'd4,
    ST_WAIT_DEC = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam int PKT_STRIDE   = 33;
  localparam int HDR_BASE     = 1;
  localparam int LLR_W        = 12;
  localparam int LLR_PER_LINE = 16;
  localparam int MAX_PKT      = 62;
  localparam int LINE_W       = LLR_W * LLR_PER_LINE;
  localparam int FIFO_W       = LINE_W + 1;

  localparam logic [9:0] N_128 = 10'd128;
  localparam logic [9:0] N_256 = 10'd256;
  localparam logic [9:0] N_512 = 10'd512;

  function automatic logic n_legal(input logic [9:0] n);
    return (n == N_128) || (n == N_256) || (n == N_512);
  endfunction

  function automatic logic [10:0] hdr_addr(input logic [6:0] pkt);
    return 11'(HDR_BASE) + 11'(pkt) * 11'(PKT_STRIDE);
  endfunction

endpackage

// File: rtl/llr_fetch_ctrl_skid_fifo.sv
// Two-entry FIFO holding returned LLR lines plus their last flag. The caller
// guarantees no push into a full FIFO unless a pop happens in the same cycle.
module llr_skid_fifo
  import llr_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FIFO_W-1:0] din,
  input  logic              pop,
  output logic [FIFO_W-1:0] dout,
  output logic              empty,
  output logic [1:0]        count
);

  logic [FIFO_W-1:0] slot [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= din;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = slot[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/llr_fetch_ctrl.sv
// Walks the packet list in LLR memory, presents each packet's config to the
// decoder core and streams its LLR lines through a credit-managed 2-entry FIFO.
module llr_fetch_ctrl
  import llr_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              module_en,
  output logic [10:0]       raddr,
  input  logic [LINE_W-1:0] rdata,
  output logic              cfg_valid,
  output logic [9:0]        cfg_n,
  output logic [7:0]        cfg_k,
  output logic [6:0]        cfg_pkt,
  output logic              llr_valid,
  output logic [LINE_W-1:0] llr_data,
  output logic              llr_last,
  input  logic              llr_ready,
  input  logic              dec_done,
  output logic              busy,
  output logic              proc_done,
  output logic              err,
  output state_t            state_dbg
);

  // Handshake: a line transfers on a rising edge where llr_valid and
  // llr_ready are both 1; llr_data/llr_last hold while valid waits for ready.

  state_t            state, state_next;
  logic [6:0]        pkt, pkt_total;
  logic [5:0]        lines, iss_cnt, line_idx;
  logic              inflight, inflight_last;
  logic              start, pop, issue, hdr_ok, pkt_last, pkt_adv;
  logic [6:0]        cnt_raw;
  logic [9:0]        hdr_n;
  logic [7:0]        hdr_k;
  logic [FIFO_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic [1:0]        fifo_count;

  assign cnt_raw  = rdata[6:0];
  assign hdr_n    = rdata[9:0];
  assign hdr_k    = rdata[17:10];
  assign hdr_ok   = n_legal(hdr_n);
  assign pkt_last = (pkt == pkt_total - 7'd1);
  assign start    = module_en && !busy && (state == ST_IDLE);
  assign pop      = llr_valid && llr_ready;

  // A slot freed by this cycle's pop may be reclaimed at once, which is what
  // lets two slots sustain one line per cycle across the 1-cycle read latency.
  assign issue = (state == ST_STREAM) && (iss_cnt < lines) &&
                 ({1'b0, fifo_count} + {2'b00, inflight} <= 3'd1 + {2'b00, pop});

  // Past the final line the address parks on it so it never leaves the packet.
  assign line_idx = (iss_cnt < lines) ? iss_cnt : lines - 6'd1;

  always_comb begin
    state_next = state;
    raddr      = '0;
    pkt_adv    = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_next = ST_RD_CNT;
      ST_RD_CNT: state_next = (cnt_raw == 7'd0) ? ST_DONE : ST_RD_HDR;
      ST_RD_HDR: begin
        raddr      = hdr_addr(pkt);
        state_next = ST_CFG;
      end
      ST_CFG: begin
        if (hdr_ok) state_next = ST_STREAM;
        else if (pkt_last) state_next = ST_DONE;
        else begin
          state_next = ST_RD_HDR;
          pkt_adv    = 1'b1;
        end
      end
      ST_STREAM: begin
        raddr = hdr_addr(pkt) + 11'd1 + 11'(line_idx);
        if (pop && fifo_dout[FIFO_W-1]) state_next = ST_WAIT_DEC;
      end
      ST_WAIT_DEC: begin
        if (dec_done) begin
          if (pkt_last) state_next = ST_DONE;
          else begin
            state_next = ST_RD_HDR;
            pkt_adv    = 1'b1;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pkt           <= '0;
      pkt_total     <= '0;
      lines         <= '0;
      iss_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      cfg_valid     <= 1'b0;
      cfg_n         <= '0;
      cfg_k         <= '0;
      cfg_pkt       <= '0;
      busy          <= 1'b0;
      proc_done     <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_next;
      cfg_valid     <= 1'b0;
      proc_done     <= (state == ST_DONE);
      inflight      <= issue;
      inflight_last <= issue && (iss_cnt == lines - 6'd1);
      if (issue) iss_cnt <= iss_cnt + 6'd1;
      if (start) begin
        busy <= 1'b1;
        err  <= 1'b0;
      end else if (proc_done) begin
        busy <= 1'b0;
      end
      if (state == ST_RD_CNT) begin
        pkt <= '0;
        if (cnt_raw > 7'(MAX_PKT)) begin
          pkt_total <= 7'(MAX_PKT);
          err       <= 1'b1;
        end else begin
          pkt_total <= cnt_raw;
        end
      end
      if (state == ST_CFG) begin
        if (hdr_ok) begin
          cfg_valid <= 1'b1;
          cfg_n     <= hdr_n;
          cfg_k     <= hdr_k;
          cfg_pkt   <= pkt;
          lines     <= hdr_n[9:4];
          iss_cnt   <= '0;
        end else begin
          err <= 1'b1;
        end
      end
      if (pkt_adv) pkt <= pkt + 7'd1;
    end
  end

  llr_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({inflight_last, rdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign llr_valid = !fifo_empty;
  assign llr_data  = fifo_dout[LINE_W-1:0];
  assign llr_last  = fifo_dout[FIFO_W-1];
  assign state_dbg = state;

endmodule

// File: tb/tb_llr_fetch_ctrl.sv
// Randomized bench for llr_fetch_ctrl: a memory model plus a packet-level
// reference that predicts config pulses, the line stream, err and addresses.
module tb_llr_fetch_ctrl;
  import llr_fetch_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         module_en;
  logic [10:0]  raddr;
  logic [191:0] rdata;
  logic         cfg_valid;
  logic [9:0]   cfg_n;
  logic [7:0]   cfg_k;
  logic [6:0]   cfg_pkt;
  logic         llr_valid;
  logic [191:0] llr_data;
  logic         llr_last;
  logic         llr_ready;
  logic         dec_done;
  logic         busy;
  logic         proc_done;
  logic         err;
  state_t       state_dbg;

  llr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .module_en(module_en), .raddr(raddr), .rdata(rdata),
    .cfg_valid(cfg_valid), .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_pkt(cfg_pkt),
    .llr_valid(llr_valid), .llr_data(llr_data), .llr_last(llr_last),
    .llr_ready(llr_ready), .dec_done(dec_done), .busy(busy),
    .proc_done(proc_done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous LLR memory: data appears the cycle after the address
  logic [191:0] mem [0:2047];
  always @(posedge clk) rdata <= mem[raddr];

  // scoreboard state
  logic [192:0] exp_q[$];
  logic [24:0]  exp_cfg_q[$];
  int           exp_cfg_n, exp_max;
  logic         exp_err;
  int           n_chk = 0, n_fail = 0;
  string        cur_test = "reset";

  int  cyc = 0, start_cyc, first_cfg_cyc, first_valid_cyc, pd_cyc;
  int  pd_cnt, cfg_cnt, line_cnt, dec_wait, max_addr, rdy_mode;
  int  acc_cyc_q[$];
  bit  mon_en = 0, noise_en = 0, start_pend = 0, prev_pd = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h exp=%0h", cur_test, tag, got, exp);
    end
  endtask

  // reference model: packet-level walk of the memory map
  function automatic void build_model();
    int p_cnt, hdr, n, nl;
    exp_q.delete();
    exp_cfg_q.delete();
    exp_err = 1'b0;
    exp_max = 0;
    p_cnt = int'(mem[0][6:0]);
    if (p_cnt > 62) begin
      p_cnt   = 62;
      exp_err = 1'b1;
    end
    for (int p = 0; p < p_cnt; p++) begin
      hdr = 1 + 33 * p;
      if (hdr > exp_max) exp_max = hdr;
      n = int'(mem[hdr][9:0]);
      if (n == 128 || n == 256 || n == 512) begin
        exp_cfg_q.push_back({7'(p), mem[hdr][17:10], mem[hdr][9:0]});
        nl = n / 16;
        for (int i = 0; i < nl; i++) begin
          exp_q.push_back({(i == nl - 1), mem[hdr + 1 + i]});
          if (hdr + 1 + i > exp_max) exp_max = hdr + 1 + i;
        end
      end else begin
        exp_err = 1'b1;
      end
    end
    exp_cfg_n = exp_cfg_q.size();
  endfunction

  // driver + monitor, all at the falling edge
  always @(negedge clk) begin
    cyc++;
    case (rdy_mode)
      1:       llr_ready = ~llr_ready;
      2:       llr_ready = 1'($urandom_range(0, 1));
      default: llr_ready = 1'b1;
    endcase
    dec_done = 1'b0;
    if (dec_wait > 0) begin
      dec_wait--;
      if (dec_wait == 0) dec_done = 1'b1;
    end
    module_en = noise_en && busy && ($urandom_range(0, 3) == 0);
    if (start_pend) begin
      module_en  = 1'b1;
      start_pend = 0;
      start_cyc  = cyc;
    end
    if (mon_en) begin
      if (int'(raddr) > max_addr) max_addr = int'(raddr);
      if (cyc == start_cyc + 1) chk("busy_rise", busy, 1'b1);
      if (cfg_valid) begin
        cfg_cnt++;
        if (first_cfg_cyc < 0) first_cfg_cyc = cyc;
        if (exp_cfg_q.size() == 0) chk("cfg_extra", 1, 0);
        else chk("cfg", {cfg_pkt, cfg_k, cfg_n}, exp_cfg_q.pop_front());
      end
      if (llr_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) chk("line_extra", 1, 0);
        else begin
          chk("line", {llr_last, llr_data}, exp_q[0]);
          if (llr_ready) begin
            void'(exp_q.pop_front());
            line_cnt++;
            acc_cyc_q.push_back(cyc);
            if (llr_last) dec_wait = 5;
          end
        end
      end
      if (prev_pd) chk("busy_fall", busy, 1'b0);
      if (proc_done) begin
        pd_cnt++;
        pd_cyc = cyc;
        chk("busy_at_done", busy, 1'b1);
      end
      prev_pd = proc_done;
    end
  end

  task automatic chk_outputs_zero();
    chk("z_raddr", raddr, 0);
    chk("z_cfg_valid", cfg_valid, 0);
    chk("z_cfg_n", cfg_n, 0);
    chk("z_cfg_k", cfg_k, 0);
    chk("z_cfg_pkt", cfg_pkt, 0);
    chk("z_llr_valid", llr_valid, 0);
    chk("z_llr_data", llr_data, 0);
    chk("z_llr_last", llr_last, 0);
    chk("z_busy", busy, 0);
    chk("z_proc_done", proc_done, 0);
    chk("z_err", err, 0);
  endtask

  task automatic fill_mem(input int p_word);
    for (int i = 0; i < 2048; i++)
      mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    mem[0][6:0] = 7'(p_word);
  endtask

  task automatic set_hdr(input int p, input int n, input int k);
    mem[1 + 33 * p][9:0]   = 10'(n);
    mem[1 + 33 * p][17:10] = 8'(k);
  endtask

  task automatic clear_run();
    start_cyc = -10; first_cfg_cyc = -1; first_valid_cyc = -1; pd_cyc = -1;
    pd_cnt = 0; cfg_cnt = 0; line_cnt = 0; dec_wait = 0; max_addr = 0;
    prev_pd = 0;
    acc_cyc_q.delete();
  endtask

  task automatic launch(input int mode, input bit noise);
    build_model();
    clear_run();
    rdy_mode = mode;
    noise_en = noise;
    mon_en   = 1;
    @(posedge clk);
    start_pend = 1;
  endtask

  task automatic run_test(input int mode, input bit noise);
    bit done;
    launch(mode, noise);
    done = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (pd_cnt > 0) begin
        done = 1;
        break;
      end
    end
    chk("done_in_budget", done, 1'b1);
    repeat (3) @(negedge clk);
    chk("cfg_cnt", cfg_cnt, exp_cfg_n);
    chk("cfg_left", exp_cfg_q.size(), 0);
    chk("line_left", exp_q.size(), 0);
    chk("err", err, exp_err);
    chk("proc_done_cnt", pd_cnt, 1);
    chk("max_raddr", max_addr, exp_max);
    mon_en   = 0;
    noise_en = 0;
  endtask

  initial begin
    int  sel, n;
    bit  got_lines;
    rst = 1'b1; module_en = 1'b0; dec_done = 1'b0; llr_ready = 1'b1; rdy_mode = 0;
    fill_mem(0);
    clear_run();
    repeat (4) @(negedge clk);
    chk_outputs_zero();
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero();

    cur_test = "two_pkt";
    fill_mem(2);
    set_hdr(0, 128, 64);
    set_hdr(1, 512, 256);
    run_test(0, 0);
    chk("cfg_to_valid", first_valid_cyc - first_cfg_cyc, 2);
    chk("acc_count", acc_cyc_q.size(), 40);
    if (acc_cyc_q.size() == 40) begin
      chk("pkt0_rate", acc_cyc_q[7] - acc_cyc_q[0], 7);
      chk("pkt1_rate", acc_cyc_q[39] - acc_cyc_q[8], 31);
    end

    cur_test = "toggle_ready";
    fill_mem(1);
    set_hdr(0, 256, 17);
    run_test(1, 0);
    chk("lines16", line_cnt, 16);

    cur_test = "zero_pkt";
    fill_mem(0);
    run_test(0, 0);
    chk("p0_latency", pd_cyc - start_cyc, 3);
    chk("p0_no_cfg", cfg_cnt, 0);

    cur_test = "bad_n";
    fill_mem(3);
    set_hdr(0, 128, 5);
    set_hdr(1, 300, 6);
    set_hdr(2, 256, 7);
    run_test(2, 0);
    chk("bad_n_err", err, 1'b1);

    cur_test = "clamp";
    fill_mem(100);
    for (int p = 0; p < 62; p++) set_hdr(p, (p == 61) ? 512 : 128, p);
    run_test(2, 1);
    chk("cfg_cnt62", cfg_cnt, 62);
    chk("last_addr", max_addr, 2046);

    cur_test = "mid_reset";
    fill_mem(1);
    set_hdr(0, 512, 99);
    launch(0, 0);
    got_lines = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (line_cnt >= 4) begin
        got_lines = 1;
        break;
      end
    end
    chk("reached_stream", got_lines, 1'b1);
    mon_en = 0;
    rst    = 1'b1;
    @(negedge clk);
    chk_outputs_zero();
    @(negedge clk);
    chk_outputs_zero();
    rst      = 1'b0;
    dec_wait = 0;
    @(negedge clk);
    cur_test = "after_reset";
    run_test(0, 0);

    for (int r = 0; r < 3; r++) begin
      cur_test = $sformatf("random%0d", r);
      fill_mem($urandom_range(1, 5));
      for (int p = 0; p < 5; p++) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0: n = 128;
          1: n = 256;
          2: n = 512;
          3: n = 300;
          default: n = 64;
        endcase
        set_hdr(p, n, $urandom_range(0, 255));
      end
      run_test(2, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
